// File: rtl/lv1_lv2_arb_pkg.sv
// Shared types for the L1-L2 bus arbiter: state encoding,
// core index type and a one-hot helper.
package lv1_lv2_arb_pkg;

    localparam int NUM_CORES = 4;

    typedef logic [1:0] core_idx_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PROC  = 2'd1,
        ST_SNOOP = 2'd2,
        ST_LV2   = 2'd3
    } arb_state_e;

    function automatic logic [NUM_CORES-1:0] idx2oh(input core_idx_t idx);
        logic [NUM_CORES-1:0] oh;
        oh = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/lv1_lv2_bus_arbiter_rr_pick4.sv
// rr_pick4: combinational 4-way round-robin picker.
// Search starts at ptr_i and wraps; masked bits never win.
module rr_pick4
    import lv1_lv2_arb_pkg::*;
(
    input  logic [NUM_CORES-1:0] req_i,
    input  core_idx_t            ptr_i,
    input  logic [NUM_CORES-1:0] mask_i,
    output logic [NUM_CORES-1:0] gnt_o,
    output core_idx_t            idx_o,
    output logic                 valid_o
);

    logic [NUM_CORES-1:0] eff;

    assign eff = req_i & ~mask_i;

    // Walk offsets from farthest to nearest so the nearest hit wins.
    always_comb begin
        gnt_o   = '0;
        idx_o   = ptr_i;
        valid_o = 1'b0;
        for (int i = NUM_CORES - 1; i >= 0; i--) begin
            if (eff[ptr_i + core_idx_t'(i)]) begin
                idx_o   = ptr_i + core_idx_t'(i);
                valid_o = 1'b1;
            end
        end
        if (valid_o) begin
            gnt_o = idx2oh(idx_o);
        end
    end

endmodule

// File: rtl/lv1_lv2_bus_arbiter.sv
// Grant controller for the shared L1-L2 bus; nested snoop/L2 grants.
// Optional watchdog enabled by defining ARB_TIMEOUT_EN.
module lv1_lv2_bus_arbiter
    import lv1_lv2_arb_pkg::*;
#(
    parameter int NUM_CORES      = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_CORES-1:0] bus_lv1_lv2_req_proc,
    input  logic [NUM_CORES-1:0] bus_lv1_lv2_req_snoop,
    input  logic                 bus_lv1_lv2_req_lv2,
    output logic [NUM_CORES-1:0] bus_lv1_lv2_gnt_proc,
    output logic [NUM_CORES-1:0] bus_lv1_lv2_gnt_snoop,
    output logic                 bus_lv1_lv2_gnt_lv2,
    output logic                 arb_timeout
);

    arb_state_e           state_q, state_d;
    core_idx_t            owner_q, owner_d;
    core_idx_t            snp_q, snp_d;
    core_idx_t            pptr_q, pptr_d;
    core_idx_t            sptr_q, sptr_d;
    logic [NUM_CORES-1:0] gp_q, gp_d;
    logic [NUM_CORES-1:0] gs_q, gs_d;
    logic                 gl_q, gl_d;
    logic                 expire;

    logic [NUM_CORES-1:0] p_gnt, s_gnt;
    core_idx_t            p_idx, s_idx;
    logic                 p_vld, s_vld;
    logic                 own_req;

    rr_pick4 u_pick_proc (
        .req_i   (bus_lv1_lv2_req_proc),
        .ptr_i   (pptr_q),
        .mask_i  ('0),
        .gnt_o   (p_gnt),
        .idx_o   (p_idx),
        .valid_o (p_vld)
    );

    rr_pick4 u_pick_snoop (
        .req_i   (bus_lv1_lv2_req_snoop),
        .ptr_i   (sptr_q),
        .mask_i  (gp_q),
        .gnt_o   (s_gnt),
        .idx_o   (s_idx),
        .valid_o (s_vld)
    );

    assign own_req = bus_lv1_lv2_req_proc[owner_q];

`ifdef ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          to_q, to_d;

    // Grant has been held for TIMEOUT_CYCLES cycles in this state.
    assign expire = (state_q != ST_IDLE) &&
                    (cnt_q == CW'(TIMEOUT_CYCLES - 1));

    // Count cycles spent in the current granted state.
    always_comb begin
        cnt_d = '0;
        to_d  = to_q | expire;
        if (state_d == state_q && state_q != ST_IDLE) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Watchdog registers; the flag is sticky until reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
            to_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            to_q  <= to_d;
        end
    end

    assign arb_timeout = to_q;
`else
    assign expire      = 1'b0;
    assign arb_timeout = 1'b0;
`endif

    // Next-state, pointer and grant selection.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        snp_d   = snp_q;
        pptr_d  = pptr_q;
        sptr_d  = sptr_q;
        gp_d    = gp_q;
        gs_d    = gs_q;
        gl_d    = gl_q;
        unique case (state_q)
            ST_IDLE: begin
                if (p_vld) begin
                    state_d = ST_PROC;
                    owner_d = p_idx;
                    gp_d    = p_gnt;
                end
            end
            ST_PROC: begin
                if (!own_req) begin
                    state_d = ST_IDLE;
                    pptr_d  = owner_q + 1'b1;
                    gp_d    = '0;
                end else if (s_vld) begin
                    state_d = ST_SNOOP;
                    snp_d   = s_idx;
                    gs_d    = s_gnt;
                end else if (bus_lv1_lv2_req_lv2) begin
                    state_d = ST_LV2;
                    gl_d    = 1'b1;
                end
            end
            ST_SNOOP: begin
                if (!own_req) begin
                    state_d = ST_IDLE;
                    pptr_d  = owner_q + 1'b1;
                    gp_d    = '0;
                    gs_d    = '0;
                end else if (!bus_lv1_lv2_req_snoop[snp_q]) begin
                    state_d = ST_PROC;
                    sptr_d  = snp_q + 1'b1;
                    gs_d    = '0;
                end
            end
            ST_LV2: begin
                if (!own_req) begin
                    state_d = ST_IDLE;
                    pptr_d  = owner_q + 1'b1;
                    gp_d    = '0;
                    gl_d    = 1'b0;
                end else if (!bus_lv1_lv2_req_lv2) begin
                    state_d = ST_PROC;
                    gl_d    = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                gp_d    = '0;
                gs_d    = '0;
                gl_d    = 1'b0;
            end
        endcase
        if (expire) begin
            state_d = ST_IDLE;
            pptr_d  = owner_q + 1'b1;
            gp_d    = '0;
            gs_d    = '0;
            gl_d    = 1'b0;
        end
    end

    // State, pointers and registered grants.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            owner_q <= '0;
            snp_q   <= '0;
            pptr_q  <= '0;
            sptr_q  <= '0;
            gp_q    <= '0;
            gs_q    <= '0;
            gl_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            snp_q   <= snp_d;
            pptr_q  <= pptr_d;
            sptr_q  <= sptr_d;
            gp_q    <= gp_d;
            gs_q    <= gs_d;
            gl_q    <= gl_d;
        end
    end

    assign bus_lv1_lv2_gnt_proc  = gp_q;
    assign bus_lv1_lv2_gnt_snoop = gs_q;
    assign bus_lv1_lv2_gnt_lv2   = gl_q;

endmodule

// File: tb/tb_lv1_lv2_bus_arbiter.sv
// Bench for lv1_lv2_bus_arbiter: vector table plus corner sequences.
// Expected outputs queued at drive time, compared after the edge.
module tb_lv1_lv2_bus_arbiter;

    typedef struct {
        logic       rst_n;
        logic [3:0] rp;
        logic [3:0] rs;
        logic       rl;
        logic [3:0] gp;
        logic [3:0] gs;
        logic       gl;
        string      name;
    } vec_t;

    typedef struct {
        logic [3:0] gp;
        logic [3:0] gs;
        logic       gl;
        logic       to;
        string      name;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic [3:0] req_proc;
    logic [3:0] req_snoop;
    logic       req_lv2;
    logic [3:0] gnt_proc;
    logic [3:0] gnt_snoop;
    logic       gnt_lv2;
    logic       timeout;

    int checks;
    int errors;

    vec_t vq[$];
    exp_t sb[$];

    lv1_lv2_bus_arbiter #(
        .NUM_CORES      (4),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .bus_lv1_lv2_req_proc  (req_proc),
        .bus_lv1_lv2_req_snoop (req_snoop),
        .bus_lv1_lv2_req_lv2   (req_lv2),
        .bus_lv1_lv2_gnt_proc  (gnt_proc),
        .bus_lv1_lv2_gnt_snoop (gnt_snoop),
        .bus_lv1_lv2_gnt_lv2   (gnt_lv2),
        .arb_timeout           (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout sim did not finish");
        $fatal(1, "time limit");
    end

    task automatic step(
        input logic       r,
        input logic [3:0] rp,
        input logic [3:0] rs,
        input logic       rl,
        input logic [3:0] egp,
        input logic [3:0] egs,
        input logic       egl,
        input logic       eto,
        input string      nm
    );
        exp_t e;
        @(negedge clk);
        rst_n     = r;
        req_proc  = rp;
        req_snoop = rs;
        req_lv2   = rl;
        e = '{egp, egs, egl, eto, nm};
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        checks++;
        if (gnt_proc !== e.gp || gnt_snoop !== e.gs ||
            gnt_lv2 !== e.gl || timeout !== e.to) begin
            errors++;
            $display("FAIL %s got gp=%b gs=%b gl=%b to=%b want gp=%b gs=%b gl=%b to=%b",
                     e.name, gnt_proc, gnt_snoop, gnt_lv2, timeout,
                     e.gp, e.gs, e.gl, e.to);
        end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst_n     = 1'b0;
        req_proc  = '0;
        req_snoop = '0;
        req_lv2   = 1'b0;

        vq.push_back('{1'b0, 4'b0000, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, "reset0"});
        vq.push_back('{1'b0, 4'b0000, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, "reset1"});
        vq.push_back('{1'b1, 4'b0101, 4'b0000, 1'b0, 4'b0001, 4'b0000, 1'b0, "rr_first"});
        vq.push_back('{1'b1, 4'b0101, 4'b0000, 1'b0, 4'b0001, 4'b0000, 1'b0, "own_hold"});
        vq.push_back('{1'b1, 4'b0100, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, "release_gap"});
        vq.push_back('{1'b1, 4'b0100, 4'b0000, 1'b0, 4'b0100, 4'b0000, 1'b0, "next_owner2"});
        vq.push_back('{1'b1, 4'b0000, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, "release2"});
        vq.push_back('{1'b1, 4'b0010, 4'b0000, 1'b0, 4'b0010, 4'b0000, 1'b0, "owner1"});
        vq.push_back('{1'b1, 4'b0010, 4'b1010, 1'b1, 4'b0010, 4'b1000, 1'b0, "snoop_over_l2"});
        vq.push_back('{1'b1, 4'b0010, 4'b1010, 1'b1, 4'b0010, 4'b1000, 1'b0, "snoop_hold"});
        vq.push_back('{1'b1, 4'b0010, 4'b0000, 1'b1, 4'b0010, 4'b0000, 1'b0, "snoop_ret_proc"});
        vq.push_back('{1'b1, 4'b0010, 4'b0000, 1'b1, 4'b0010, 4'b0000, 1'b1, "l2_grant"});
        vq.push_back('{1'b1, 4'b0010, 4'b0000, 1'b1, 4'b0010, 4'b0000, 1'b1, "l2_hold"});
        vq.push_back('{1'b1, 4'b0000, 4'b0000, 1'b1, 4'b0000, 4'b0000, 1'b0, "viol_in_l2"});
        vq.push_back('{1'b1, 4'b1111, 4'b0000, 1'b0, 4'b0100, 4'b0000, 1'b0, "viol_ptr_adv"});
        vq.push_back('{1'b1, 4'b1111, 4'b0001, 1'b0, 4'b0100, 4'b0001, 1'b0, "snoop_core0"});
        vq.push_back('{1'b0, 4'b1111, 4'b0001, 1'b0, 4'b0000, 4'b0000, 1'b0, "reset_in_snoop"});
        vq.push_back('{1'b1, 4'b1111, 4'b0000, 1'b0, 4'b0001, 4'b0000, 1'b0, "ptr_after_rst"});
        vq.push_back('{1'b1, 4'b1111, 4'b1110, 1'b0, 4'b0001, 4'b0010, 1'b0, "snoop_rr_1"});
        vq.push_back('{1'b1, 4'b1111, 4'b1100, 1'b0, 4'b0001, 4'b0000, 1'b0, "snoop_ret"});
        vq.push_back('{1'b1, 4'b1111, 4'b1100, 1'b0, 4'b0001, 4'b0100, 1'b0, "snoop_rr_2"});
        vq.push_back('{1'b1, 4'b0000, 4'b1100, 1'b0, 4'b0000, 4'b0000, 1'b0, "viol_in_snoop"});
        vq.push_back('{1'b1, 4'b0000, 4'b1111, 1'b1, 4'b0000, 4'b0000, 1'b0, "idle_ignores"});
        vq.push_back('{1'b1, 4'b0010, 4'b0000, 1'b0, 4'b0010, 4'b0000, 1'b0, "owner1_again"});
        vq.push_back('{1'b1, 4'b0010, 4'b0010, 1'b0, 4'b0010, 4'b0000, 1'b0, "own_snoop_mask"});
        vq.push_back('{1'b1, 4'b0010, 4'b0010, 1'b1, 4'b0010, 4'b0000, 1'b1, "l2_masked_snp"});
        vq.push_back('{1'b1, 4'b0010, 4'b0010, 1'b0, 4'b0010, 4'b0000, 1'b0, "l2_release"});
        vq.push_back('{1'b1, 4'b0000, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, "owner_release"});

        foreach (vq[i]) begin
            step(vq[i].rst_n, vq[i].rp, vq[i].rs, vq[i].rl,
                 vq[i].gp, vq[i].gs, vq[i].gl, 1'b0, vq[i].name);
        end

        step(1'b0, 4'b0000, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, "rr_reset");
        for (int k = 0; k < 5; k++) begin
            logic [3:0] oh;
            oh = 4'b0001 << (k % 4);
            for (int c = 0; c < 3; c++) begin
                step(1'b1, 4'b1111, 4'b0000, 1'b0, oh, 4'b0000, 1'b0, 1'b0, "rr_order");
            end
            step(1'b1, 4'b1111 & ~oh, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, "rr_gap");
        end

        step(1'b0, 4'b0000, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, "wd_reset");
`ifdef ARB_TIMEOUT_EN
        for (int n = 1; n <= 12; n++) begin
            logic [3:0] eg;
            logic       et;
            eg = (n == 9) ? 4'b0000 : 4'b0100;
            et = (n >= 9);
            step(1'b1, 4'b0100, 4'b0000, 1'b0, eg, 4'b0000, 1'b0, et, "watchdog");
        end
`else
        for (int n = 1; n <= 20; n++) begin
            step(1'b1, 4'b0100, 4'b0000, 1'b0, 4'b0100, 4'b0000, 1'b0, 1'b0, "no_watchdog");
        end
`endif
        step(1'b0, 4'b0100, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, "wd_clear");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
